// File: rtl/spi_xfer_sched_if.sv
// Requester-side handshake and SPI-master register bus of the transfer scheduler.
// The scheduler takes the slave modport; the environment driving it takes master.
interface spi_xfer_sched_if;
   logic [1:0] i_req;
   logic [7:0] i_addr0;
   logic [7:0] i_addr1;
   logic [7:0] i_data0;
   logic [7:0] i_data1;
   logic       i_lsb0;
   logic       i_lsb1;
   logic [1:0] o_gnt;
   logic [1:0] o_done;
   logic [7:0] o_rdata;
   logic       o_err;
   logic       o_busy;
   logic [3:0] o_spi_address;
   logic [7:0] o_spi_wdata;
   logic       o_spi_wr;
   logic       o_spi_rd;
   logic [7:0] i_spi_rdata;

   modport slave (
      input  i_req, i_addr0, i_addr1, i_data0, i_data1, i_lsb0, i_lsb1, i_spi_rdata,
      output o_gnt, o_done, o_rdata, o_err, o_busy,
      output o_spi_address, o_spi_wdata, o_spi_wr, o_spi_rd
   );

   modport master (
      output i_req, i_addr0, i_addr1, i_data0, i_data1, i_lsb0, i_lsb1, i_spi_rdata,
      input  o_gnt, o_done, o_rdata, o_err, o_busy,
      input  o_spi_address, o_spi_wdata, o_spi_wr, o_spi_rd
   );
endinterface

// File: rtl/spi_xfer_sched.sv
// Two-requester SPI transfer scheduler: round-robin grant, addr/data/ctrl writes,
// status polling with a timeout-driven recovery, then a single read-back.
module spi_xfer_sched #(
   parameter int START_WAIT = 4,
   parameter int POLL_GAP   = 8,
   parameter int TIMEOUT    = 4000
) (
   input  logic            i_ck,
   input  logic            i_rstn,
   spi_xfer_sched_if.slave bus
);
   typedef enum logic [3:0] {
      IDLE, WR_ADDR, WR_DATA, WR_CTRL, WAIT, POLL, CHK, GAP, RD, CAPT, RECOVER, DONE
   } state_t;

   localparam logic [15:0] TMO       = 16'(TIMEOUT);
   localparam logic [15:0] WAIT_LAST = 16'(START_WAIT - 1);
   localparam logic [15:0] GAP_LAST  = 16'(POLL_GAP - 1);

   state_t      state;
   logic [15:0] tcnt;
   logic [15:0] cyc;
   logic [7:0]  addr_q;
   logic [7:0]  data_q;
   logic        lsb_q;
   logic        rr_last;
   logic        pick;
   logic        tmo;
   logic        cnt_on;

   // rr_last holds the requester served last; a tie goes to the other one
   assign pick   = (bus.i_req == 2'b11) ? ~rr_last : bus.i_req[1];
   // fires in the cycle whose closing edge brings the counter to TIMEOUT
   assign tmo    = ({1'b0, tcnt} + 17'd1) >= {1'b0, TMO};
   assign cnt_on = state inside {WR_CTRL, WAIT, POLL, CHK, GAP, RD, CAPT, RECOVER};
   assign bus.o_busy = (state != IDLE);

   always_ff @(posedge i_ck or negedge i_rstn) begin
      if (!i_rstn) begin
         state             <= IDLE;
         tcnt              <= '0;
         cyc               <= '0;
         addr_q            <= '0;
         data_q            <= '0;
         lsb_q             <= 1'b0;
         rr_last           <= 1'b1;
         bus.o_gnt         <= '0;
         bus.o_done        <= '0;
         bus.o_rdata       <= '0;
         bus.o_err         <= 1'b0;
         bus.o_spi_address <= '0;
         bus.o_spi_wdata   <= '0;
         bus.o_spi_wr      <= 1'b0;
         bus.o_spi_rd      <= 1'b0;
      end else begin
         // strobes and bus fields are one-cycle; each branch sets up the next state's
         bus.o_spi_wr      <= 1'b0;
         bus.o_spi_rd      <= 1'b0;
         bus.o_spi_address <= '0;
         bus.o_spi_wdata   <= '0;
         bus.o_done        <= '0;
         if (cnt_on && tcnt != 16'hFFFF) tcnt <= tcnt + 16'd1;

         case (state)
            IDLE: if (|bus.i_req) begin
               rr_last           <= pick;
               bus.o_gnt         <= pick ? 2'b10 : 2'b01;
               addr_q            <= pick ? bus.i_addr1 : bus.i_addr0;
               data_q            <= pick ? bus.i_data1 : bus.i_data0;
               lsb_q             <= pick ? bus.i_lsb1  : bus.i_lsb0;
               bus.o_spi_wr      <= 1'b1;
               bus.o_spi_address <= 4'd2;
               bus.o_spi_wdata   <= pick ? bus.i_addr1 : bus.i_addr0;
               state             <= WR_ADDR;
            end
            WR_ADDR: begin
               bus.o_spi_wr      <= 1'b1;
               bus.o_spi_address <= 4'd1;
               bus.o_spi_wdata   <= data_q;
               state             <= WR_DATA;
            end
            WR_DATA: begin
               bus.o_spi_wr    <= 1'b1;
               bus.o_spi_wdata <= {4'b0, lsb_q, 3'b001};
               tcnt            <= '0;
               state           <= WR_CTRL;
            end
            WR_CTRL: begin
               cyc <= '0;
               if (START_WAIT == 0) begin
                  bus.o_spi_rd <= 1'b1;
                  state        <= POLL;
               end else begin
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (tmo) begin
                  bus.o_spi_wr <= 1'b1;
                  state        <= RECOVER;
               end else if (cyc == WAIT_LAST) begin
                  bus.o_spi_rd <= 1'b1;
                  state        <= POLL;
               end else begin
                  cyc <= cyc + 16'd1;
               end
            end
            POLL: begin
               if (tmo) begin
                  bus.o_spi_wr <= 1'b1;
                  state        <= RECOVER;
               end else begin
                  state <= CHK;
               end
            end
            CHK: begin
               if (tmo) begin
                  bus.o_spi_wr <= 1'b1;
                  state        <= RECOVER;
               end else if (!bus.i_spi_rdata[0]) begin
                  bus.o_spi_rd      <= 1'b1;
                  bus.o_spi_address <= 4'd3;
                  state             <= RD;
               end else if (POLL_GAP == 0) begin
                  bus.o_spi_rd <= 1'b1;
                  state        <= POLL;
               end else begin
                  cyc   <= '0;
                  state <= GAP;
               end
            end
            GAP: begin
               if (tmo) begin
                  bus.o_spi_wr <= 1'b1;
                  state        <= RECOVER;
               end else if (cyc == GAP_LAST) begin
                  bus.o_spi_rd <= 1'b1;
                  state        <= POLL;
               end else begin
                  cyc <= cyc + 16'd1;
               end
            end
            RD: state <= CAPT;
            CAPT: begin
               bus.o_rdata <= bus.i_spi_rdata;
               bus.o_err   <= 1'b0;
               bus.o_done  <= bus.o_gnt;
               bus.o_gnt   <= '0;
               state       <= DONE;
            end
            RECOVER: begin
               bus.o_rdata <= 8'h00;
               bus.o_err   <= 1'b1;
               bus.o_done  <= bus.o_gnt;
               bus.o_gnt   <= '0;
               state       <= DONE;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_xfer_sched.sv
// Randomized scoreboard bench for spi_xfer_sched with an SPI register-slave responder
// and a timeline-level reference model of each transfer's outcome.
module tb_spi_xfer_sched;
   localparam int SW = 4;
   localparam int PG = 8;
   localparam int TO = 117;

   typedef struct {
      int         owner;
      logic [7:0] addr;
      logic [7:0] data;
      logic       lsb;
      logic [7:0] rval;
      logic       err;
      int         npolls;
      int         dur;
   } exp_t;

   logic i_ck;
   logic i_rstn;
   spi_xfer_sched_if bus();

   spi_xfer_sched #(.START_WAIT(SW), .POLL_GAP(PG), .TIMEOUT(TO)) dut (
      .i_ck   (i_ck),
      .i_rstn (i_rstn),
      .bus    (bus)
   );

   initial i_ck = 1'b0;
   always #5 i_ck = ~i_ck;

   int         checks = 0;
   int         passed = 0;
   exp_t       sbq[$];
   int         rr_last = 1;
   int         busy_of[256];
   logic [7:0] rval_of[256];

   task automatic check(string name, longint act, longint exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Outcome from the timeline: the clearing status read lands SW+2+busy*(PG+2)
   // cycles after the ctrl write; anything reaching TIMEOUT-1 first is abandoned.
   function automatic exp_t model(int r, logic [7:0] a, logic [7:0] d, logic l, int busy,
                                  logic [7:0] rv);
      exp_t e;
      int   chk_at;
      e.owner = r; e.addr = a; e.data = d; e.lsb = l;
      chk_at = (busy >= 255) ? 32'h3fff_ffff : SW + 2 + busy * (PG + 2);
      if (chk_at >= TO - 1) begin
         e.err = 1'b1; e.rval = 8'h00; e.dur = TO + 1;
         e.npolls = (TO - 2 - SW) / (PG + 2) + 1;
      end else begin
         e.err = 1'b0; e.rval = rv; e.dur = chk_at + 3; e.npolls = busy + 1;
      end
      return e;
   endfunction

   // SPI register slave: status stays busy for busy_of[addr] polls (255 = forever)
   logic [7:0] cap_addr;
   int         busy_left;
   always @(posedge i_ck or negedge i_rstn) begin
      if (!i_rstn) begin
         bus.i_spi_rdata <= 8'h00;
         busy_left       <= 0;
         cap_addr        <= 8'h00;
      end else begin
         if (bus.o_spi_wr && bus.o_spi_address == 4'd2) cap_addr <= bus.o_spi_wdata;
         if (bus.o_spi_wr && bus.o_spi_address == 4'd0 && bus.o_spi_wdata[0])
            busy_left <= busy_of[cap_addr];
         if (bus.o_spi_rd && bus.o_spi_address == 4'd0) begin
            bus.i_spi_rdata <= {7'($urandom), busy_left != 0};
            if (busy_left != 0 && busy_left < 255) busy_left <= busy_left - 1;
         end else if (bus.o_spi_rd && bus.o_spi_address == 4'd3) begin
            bus.i_spi_rdata <= rval_of[cap_addr];
         end else begin
            bus.i_spi_rdata <= 8'($urandom);
         end
      end
   end

   int cyc = 0;
   always @(posedge i_ck) cyc <= cyc + 1;

   int          ctrl_cyc, rec_cyc, last_poll, npolls, bad_proto;
   logic [7:0]  held_rdata;
   logic        held_err;
   logic [11:0] wlog[$];
   exp_t        mon_e;

   initial begin : monitor
      npolls = 0; bad_proto = 0; held_rdata = 8'h00; held_err = 1'b0;
      forever begin
         @(negedge i_ck);
         if (!i_rstn) begin
            npolls = 0; bad_proto = 0; wlog.delete(); held_rdata = 8'h00; held_err = 1'b0;
         end else begin
            if (bus.o_spi_wr && bus.o_spi_rd) bad_proto++;
            if (!bus.o_spi_wr && !bus.o_spi_rd && (bus.o_spi_address != 0 || bus.o_spi_wdata != 0))
               bad_proto++;
            if (bus.o_gnt != 0 && !$onehot(bus.o_gnt)) bad_proto++;
            if (bus.o_done == 0 && (bus.o_rdata != held_rdata || bus.o_err != held_err)) bad_proto++;
            if (bus.o_spi_wr) begin
               if (wlog.size() == 0 && bus.o_spi_address == 4'd2 && sbq.size() > 0)
                  check("gnt_owner", bus.o_gnt, (sbq[0].owner == 1) ? 2 : 1);
               wlog.push_back({bus.o_spi_address, bus.o_spi_wdata});
               if (bus.o_spi_address == 4'd0 && bus.o_spi_wdata[0]) begin
                  ctrl_cyc = cyc; npolls = 0;
               end
               if (bus.o_spi_address == 4'd0 && bus.o_spi_wdata == 8'h00) rec_cyc = cyc;
            end
            if (bus.o_spi_rd && bus.o_spi_address == 4'd0) begin
               if (npolls == 0) check("first_poll_delay", cyc - ctrl_cyc, SW + 1);
               else             check("poll_spacing", cyc - last_poll, PG + 2);
               last_poll = cyc;
               npolls++;
            end
            if (bus.o_done != 0) begin
               if (sbq.size() == 0) begin
                  check("unexpected_done", bus.o_done, 0);
               end else begin
                  mon_e = sbq.pop_front();
                  check("done_owner", bus.o_done, (mon_e.owner == 1) ? 2 : 1);
                  check("gnt_in_done", bus.o_gnt, 0);
                  check("busy_in_done", bus.o_busy, 1);
                  check("rdata", bus.o_rdata, mon_e.rval);
                  check("err", bus.o_err, mon_e.err);
                  check("npolls", npolls, mon_e.npolls);
                  check("done_latency", cyc - ctrl_cyc, mon_e.dur);
                  check("nwrites", wlog.size(), mon_e.err ? 4 : 3);
                  if (wlog.size() >= 3) begin
                     check("wr_addr", wlog[0], {4'd2, mon_e.addr});
                     check("wr_data", wlog[1], {4'd1, mon_e.data});
                     check("wr_ctrl", wlog[2], {4'd0, mon_e.lsb ? 8'h09 : 8'h01});
                  end
                  if (mon_e.err && wlog.size() >= 4) begin
                     check("wr_recover", wlog[3], 12'h000);
                     check("recover_at", rec_cyc - ctrl_cyc, TO);
                  end
                  check("protocol", bad_proto, 0);
               end
               held_rdata = bus.o_rdata; held_err = bus.o_err;
               wlog.delete(); npolls = 0; bad_proto = 0;
            end
         end
      end
   end

   task automatic set_ops(int r, logic [7:0] a, logic [7:0] d, logic l);
      if (r == 0) begin bus.i_addr0 = a; bus.i_data0 = d; bus.i_lsb0 = l; end
      else        begin bus.i_addr1 = a; bus.i_data1 = d; bus.i_lsb1 = l; end
   endtask

   task automatic wait_bit(string name, int r, bit is_done, int limit);
      int n = 0;
      do begin
         @(negedge i_ck);
         n++;
      end while (n < limit && !(is_done ? bus.o_done[r] : bus.o_gnt[r]));
      check(name, n < limit, 1);
   endtask

   task automatic wait_any_done(int limit);
      int n = 0;
      do begin
         @(negedge i_ck);
         n++;
      end while (n < limit && bus.o_done == 2'b00);
      check("any_done_bound", n < limit, 1);
   endtask

   task automatic xfer(int r, logic [7:0] a, logic [7:0] d, logic l, int busy,
                       logic [7:0] rv, bit mess);
      busy_of[a] = busy;
      rval_of[a] = rv;
      set_ops(r, a, d, l);
      sbq.push_back(model(r, a, d, l, busy, rv));
      rr_last = r;
      bus.i_req[r] = 1'b1;
      if (mess) begin
         wait_bit("gnt_bound", r, 1'b0, 10);
         set_ops(r, ~a, ~d, ~l);
         if ($urandom_range(0, 1) == 1) bus.i_req[r] = 1'b0;
      end
      wait_bit("done_bound", r, 1'b1, 400);
      bus.i_req[r] = 1'b0;
   endtask

   task automatic both_held(int k);
      logic [7:0] a0, d0, v0, d1, v1;
      logic       l0, l1;
      int         o;
      a0 = 8'($urandom); d0 = 8'($urandom); v0 = 8'($urandom); l0 = 1'($urandom);
      d1 = 8'($urandom); v1 = 8'($urandom); l1 = 1'($urandom);
      busy_of[a0] = $urandom_range(0, 3);          rval_of[a0] = v0;
      busy_of[a0 ^ 8'h80] = $urandom_range(0, 3);  rval_of[a0 ^ 8'h80] = v1;
      set_ops(0, a0, d0, l0);
      set_ops(1, a0 ^ 8'h80, d1, l1);
      for (int i = 0; i < k; i++) begin
         o = 1 - rr_last;
         if (o == 0) sbq.push_back(model(0, a0, d0, l0, busy_of[a0], v0));
         else        sbq.push_back(model(1, a0 ^ 8'h80, d1, l1, busy_of[a0 ^ 8'h80], v1));
         rr_last = o;
      end
      bus.i_req = 2'b11;
      for (int i = 0; i < k; i++) wait_any_done(400);
      bus.i_req = 2'b00;
   endtask

   task automatic reset_checks(string p);
      check({p, "_gnt"},   bus.o_gnt, 0);
      check({p, "_done"},  bus.o_done, 0);
      check({p, "_rdata"}, bus.o_rdata, 0);
      check({p, "_err"},   bus.o_err, 0);
      check({p, "_busy"},  bus.o_busy, 0);
      check({p, "_saddr"}, bus.o_spi_address, 0);
      check({p, "_wdata"}, bus.o_spi_wdata, 0);
      check({p, "_wr"},    bus.o_spi_wr, 0);
      check({p, "_rd"},    bus.o_spi_rd, 0);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, checks);
      $fatal(1);
   end

   initial begin : stim
      int n;
      int saw_done;
      logic [7:0] a;
      bus.i_req = 2'b00;
      set_ops(0, 8'h00, 8'h00, 1'b0);
      set_ops(1, 8'h00, 8'h00, 1'b0);
      i_rstn = 1'b0;
      repeat (3) @(negedge i_ck);
      reset_checks("por");
      i_rstn = 1'b1;
      @(negedge i_ck);

      xfer(0, 8'h12, 8'hA5, 1'b0, 2,   8'h3C, 1'b0);
      xfer(1, 8'h34, 8'h5A, 1'b1, 0,   8'hC3, 1'b0);
      xfer(0, 8'h56, 8'h01, 1'b0, 3,   8'h77, 1'b0);
      xfer(1, 8'h78, 8'hFF, 1'b1, 255, 8'h99, 1'b0);
      xfer(0, 8'h9A, 8'h10, 1'b1, 11,  8'h42, 1'b0);
      xfer(1, 8'hBC, 8'h20, 1'b0, 10,  8'h24, 1'b1);

      for (int i = 0; i < 20; i++) begin
         int b;
         b = ($urandom_range(0, 5) == 0) ? 255 : int'($urandom_range(0, 4));
         xfer(int'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'($urandom), b,
              8'($urandom), 1'($urandom));
      end

      both_held(6);

      // abandon a transfer mid-GAP with reset
      a = 8'($urandom);
      busy_of[a] = 255;
      set_ops(0, a, 8'h33, 1'b0);
      sbq.push_back(model(0, a, 8'h33, 1'b0, 255, 8'h00));
      bus.i_req[0] = 1'b1;
      n = 0;
      do begin
         @(negedge i_ck);
         n++;
      end while (n < 50 && !bus.o_spi_rd);
      check("poll_before_reset_bound", n < 50, 1);
      repeat (3) @(negedge i_ck);
      #2;
      i_rstn = 1'b0;
      sbq.delete();
      #1;
      reset_checks("mid_rst");
      bus.i_req = 2'b00;
      repeat (2) @(negedge i_ck);
      i_rstn = 1'b1;
      rr_last = 1;
      saw_done = 0;
      repeat (20) begin
         @(negedge i_ck);
         if (bus.o_done != 0) saw_done++;
      end
      check("no_done_after_reset", saw_done, 0);

      both_held(2);
      xfer(1, 8'h5C, 8'hE7, 1'b1, 1, 8'hD2, 1'b1);

      repeat (5) @(negedge i_ck);
      check("scoreboard_empty", sbq.size(), 0);
      check("protocol_end", bad_proto, 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/spi_xfer_sched.md
SPI_XFER_SCHED -- requirements
Module: spi_xfer_sched

Interface
REQ-001 Parameter START_WAIT, default 4, idle cycles after the ctrl write before the first status poll.
REQ-002 Parameter POLL_GAP, default 8, idle cycles between consecutive status polls.
REQ-003 Parameter TIMEOUT, default 4000, cycles from the ctrl write until a transfer is abandoned; width 16 bits.
REQ-004 i_ck  input  1  sole clock; all logic on rising edge.
REQ-005 i_rstn  input  1  reset, asynchronous, active-low.
REQ-006 i_req  input  2  per-requester transfer request, level, held until matching o_done.
REQ-007 i_addr0 / i_addr1  input  8  slave register address byte per requester.
REQ-008 i_data0 / i_data1  input  8  data byte per requester.
REQ-009 i_lsb0 / i_lsb1  input  1  1 = LSB-first transfer for that requester.
REQ-010 o_gnt  output  2  one-hot grant, high for the whole transfer of the owner.
REQ-011 o_done  output  2  one-cycle completion pulse to the owner.
REQ-012 o_rdata  output  8  received byte, valid in the o_done cycle, held until next o_done.
REQ-013 o_err  output  1  timeout flag, valid with o_done, held until next o_done.
REQ-014 o_busy  output  1  high in every state except IDLE.
REQ-015 o_spi_address  output  4  register address to SPI master bus.
REQ-016 o_spi_wdata  output  8  write data to SPI master bus.
REQ-017 o_spi_wr / o_spi_rd  output  1  one-cycle write / read strobes; never both high.
REQ-018 i_spi_rdata  input  8  SPI master read data, valid the cycle after o_spi_rd.

Function
REQ-019 States: IDLE, WR_ADDR, WR_DATA, WR_CTRL, WAIT, POLL, CHK, GAP, RD, CAPT, RECOVER, DONE.
REQ-020 IDLE: any i_req bit set -> latch owner's addr/data/lsb, assert o_gnt bit, go WR_ADDR next cycle.
REQ-021 Arbitration round-robin: both requesting -> grant the one not served last; after reset requester 0 wins.
REQ-022 WR_ADDR: o_spi_wr=1, o_spi_address=2, o_spi_wdata=addr byte, one cycle.
REQ-023 WR_DATA: o_spi_wr=1, o_spi_address=1, o_spi_wdata=data byte, one cycle.
REQ-024 WR_CTRL: o_spi_wr=1, o_spi_address=0, o_spi_wdata={4'b0, lsb, 3'b001}; timeout counter cleared to 0 here.
REQ-025 WAIT: no strobes for START_WAIT cycles, then POLL.
REQ-026 POLL: o_spi_rd=1, o_spi_address=0, one cycle, then CHK.
REQ-027 CHK: i_spi_rdata[0]==0 -> RD; else GAP (POLL_GAP strobe-free cycles) -> POLL.
REQ-028 RD: o_spi_rd=1, o_spi_address=3, one cycle; CAPT: latch i_spi_rdata into o_rdata, o_err=0, -> DONE.
REQ-029 Timeout counter increments every cycle from WR_CTRL+1 until DONE; saturates, no wrap.
REQ-030 Counter reaching TIMEOUT in WAIT, POLL, CHK or GAP -> RECOVER; timeout takes priority over CHK success in the same cycle.
REQ-031 RECOVER: o_spi_wr=1, o_spi_address=0, o_spi_wdata=8'h00, one cycle; o_rdata=8'h00, o_err=1, -> DONE.
REQ-032 DONE: o_done owner bit high one cycle, o_gnt deasserted same cycle, -> IDLE; arbitration resumes the following cycle.
REQ-033 Requests sampled only in IDLE; deassertion of i_req mid-transfer ignored, transfer completes and o_done still pulses.
REQ-034 Operands latched at grant; later changes on i_addr/i_data/i_lsb have no effect on the transfer in progress.
REQ-035 Address/wdata outputs drive 0 whenever no strobe is active.

Reset
REQ-036 i_rstn low, any state, asynchronously -> IDLE; o_gnt=0, o_done=0, o_rdata=8'h00, o_err=0, o_busy=0, o_spi_address=0, o_spi_wdata=0, o_spi_wr=0, o_spi_rd=0, timeout counter=0, round-robin pointer favours requester 0.
REQ-037 Transfer interrupted by reset produces no o_done; first request after release starts from IDLE.

Verification
REQ-038 req0 addr=8'h12 data=8'hA5 lsb=0, SPI model returns 8'h3C -> writes 2:12, 1:A5, 0:01, polls until bit0=0, reads 3; o_done=2'b01, o_rdata=8'h3C, o_err=0.
REQ-039 req1 lsb=1 -> ctrl write data 8'h09; o_done=2'b10.
REQ-040 Both requesters held continuously -> grants alternate 0,1,0,1; no back-to-back grant to the same requester.
REQ-041 SPI model never clears status bit0 -> RECOVER writes 0:00 exactly TIMEOUT cycles after WR_CTRL; o_done with o_err=1, o_rdata=8'h00.
REQ-042 Poll spacing: status busy for 3 polls -> successive o_spi_rd at address 0 separated by exactly POLL_GAP+2 cycles.
REQ-043 Reset asserted during GAP -> all outputs at reset values the same cycle, no o_done; next req0 completes normally.
